// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - recovers x/y/video_on and timing lock from a received VGA hsync/vsync pair
//
// Ports:
//   clk_100MHz   system clock
//   reset_n      asynchronous active-low reset
//   p_tick       pixel enable; all state advances only on clocks where it is 1
//   hsync_in     received horizontal sync
//   vsync_in     received vertical sync
//   x, y         recovered pixel coordinates aligned to received sync
//   video_on     locked and inside the active window (combinational from registers)
//   locked       timing lock after LOCK_FRAMES consecutive clean frames
//   frame_start  one-clock pulse when (x,y) becomes (0,0) while locked
//   h_err/v_err  one-clock pulses on horizontal / vertical timing violations
//   line_len     last measured hsync period in ticks (saturating)
//   frame_lines  last measured hsync-edge count between vsync assertion edges
module vga_sync_monitor #(
    parameter int HD          = 640,
    parameter int HTOTAL      = 800,
    parameter int HSYNC_START = 656,
    parameter int HSYNC_W     = 96,
    parameter int VD          = 480,
    parameter int VTOTAL      = 525,
    parameter int VSYNC_START = 513,
    parameter int VSYNC_W     = 2,
    parameter int SYNC_ACTIVE = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       p_tick,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       h_err,
    output logic       v_err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);

    localparam logic        SA     = 1'(SYNC_ACTIVE);
    localparam logic [9:0]  HD_L   = 10'(HD);
    localparam logic [9:0]  HT_L   = 10'(HTOTAL);
    localparam logic [10:0] HT_P   = 11'(HTOTAL);
    localparam logic [9:0]  HSS_L  = 10'(HSYNC_START);
    localparam logic [9:0]  HSW_L  = 10'(HSYNC_W);
    localparam logic [9:0]  VD_L   = 10'(VD);
    localparam logic [9:0]  VT_L   = 10'(VTOTAL);
    localparam logic [9:0]  VSS_L  = 10'(VSYNC_START);
    localparam logic [9:0]  VSW_L  = 10'(VSYNC_W);
    localparam logic [7:0]  LF_L   = 8'(LOCK_FRAMES);
    localparam logic [9:0]  SAT    = 10'd1023;

    logic       hs_q, vs_q;
    logic [9:0] hcnt_q, hcnt_d;
    logic       h_valid_q, h_valid_d;
    logic [9:0] hw_cnt_q, hw_cnt_d;
    logic       hw_armed_q, hw_armed_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [9:0] lcnt_q, lcnt_d;
    logic       v_valid_q, v_valid_d;
    logic [9:0] vw_cnt_q, vw_cnt_d;
    logic       vw_armed_q, vw_armed_d;
    logic       frame_bad_q, frame_bad_d;
    logic [7:0] good_q, good_d;
    logic       locked_q, locked_d;
    logic       frame_start_q, frame_start_d;
    logic       h_err_q, h_err_d;
    logic       v_err_q, v_err_d;
    logic [9:0] line_len_q, line_len_d;
    logic [9:0] frame_lines_q, frame_lines_d;

    logic        hs_act, hs_rise, hs_fall;
    logic        vs_act, vs_rise, vs_fall;
    logic [10:0] period;
    logic        any_err;

    assign hs_act  = (hsync_in == SA);
    assign hs_rise = hs_act && (hs_q != SA);
    assign hs_fall = !hs_act && (hs_q == SA);
    assign vs_act  = (vsync_in == SA);
    assign vs_rise = vs_act && (vs_q != SA);
    assign vs_fall = !vs_act && (vs_q == SA);
    assign period  = {1'b0, hcnt_q} + 11'd1;

    always_comb begin
        hcnt_d        = hcnt_q;
        h_valid_d     = h_valid_q;
        hw_cnt_d      = hw_cnt_q;
        hw_armed_d    = hw_armed_q;
        x_d           = x_q;
        y_d           = y_q;
        lcnt_d        = lcnt_q;
        v_valid_d     = v_valid_q;
        vw_cnt_d      = vw_cnt_q;
        vw_armed_d    = vw_armed_q;
        frame_bad_d   = frame_bad_q;
        good_d        = good_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        h_err_d       = 1'b0;
        v_err_d       = 1'b0;

        // Horizontal period, width and timeout
        if (hs_rise) begin
            hcnt_d = '0;
            if (h_valid_q) begin
                line_len_d = period[10] ? SAT : period[9:0];
                if (period != HT_P) h_err_d = 1'b1;
            end
            h_valid_d  = 1'b1;
            hw_cnt_d   = 10'd1;
            hw_armed_d = 1'b1;
        end else begin
            if (hcnt_q != SAT) hcnt_d = hcnt_q + 10'd1;
            // hcnt is about to reach saturation: the line has gone silent
            if (hcnt_q == SAT - 10'd1) begin
                h_err_d   = 1'b1;
                h_valid_d = 1'b0;
            end
            if (hs_act && hw_cnt_q != SAT) hw_cnt_d = hw_cnt_q + 10'd1;
        end
        if (hs_fall && hw_armed_q && hw_cnt_q != HSW_L) h_err_d = 1'b1;

        // Coordinate recovery
        if (hs_rise) begin
            x_d = HSS_L;
        end else if (x_q == HT_L - 10'd1) begin
            x_d = '0;
            y_d = (y_q == VT_L - 10'd1) ? '0 : y_q + 10'd1;
        end else begin
            x_d = x_q + 10'd1;
        end

        // Vertical period and width; a same-tick hsync edge belongs to the new frame
        if (vs_rise) begin
            if (v_valid_q) begin
                frame_lines_d = lcnt_q;
                if (lcnt_q != VT_L) v_err_d = 1'b1;
            end
            v_valid_d  = 1'b1;
            y_d        = VSS_L;
            lcnt_d     = 10'(hs_rise);
            vw_cnt_d   = 10'(hs_rise);
            vw_armed_d = 1'b1;
        end else begin
            if (hs_rise && lcnt_q != SAT) lcnt_d = lcnt_q + 10'd1;
            if (hs_rise && vs_act && vw_cnt_q != SAT) vw_cnt_d = vw_cnt_q + 10'd1;
        end
        if (vs_fall && vw_armed_q && vw_cnt_q != VSW_L) v_err_d = 1'b1;

        // Lock: an error at a vsync edge is charged to the frame that just ended
        any_err = h_err_d || v_err_d;
        if (any_err) good_d = '0;
        if (vs_rise) begin
            if (!any_err && v_valid_q && !frame_bad_q && good_q != LF_L)
                good_d = good_q + 8'd1;
            frame_bad_d = 1'b0;
        end else if (any_err) begin
            frame_bad_d = 1'b1;
        end
        locked_d = (good_d == LF_L);

        frame_start_d = locked_d && (x_d == '0) && (y_d == '0) &&
                        !((x_q == '0) && (y_q == '0));
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hcnt_q        <= '0;
            h_valid_q     <= 1'b0;
            hw_cnt_q      <= '0;
            hw_armed_q    <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            lcnt_q        <= '0;
            v_valid_q     <= 1'b0;
            vw_cnt_q      <= '0;
            vw_armed_q    <= 1'b0;
            frame_bad_q   <= 1'b0;
            good_q        <= '0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
        end else begin
            // Pulses are re-evaluated every clock so they never outlive one cycle
            h_err_q       <= p_tick && h_err_d;
            v_err_q       <= p_tick && v_err_d;
            frame_start_q <= p_tick && frame_start_d;
            if (p_tick) begin
                hs_q          <= hsync_in;
                vs_q          <= vsync_in;
                hcnt_q        <= hcnt_d;
                h_valid_q     <= h_valid_d;
                hw_cnt_q      <= hw_cnt_d;
                hw_armed_q    <= hw_armed_d;
                x_q           <= x_d;
                y_q           <= y_d;
                lcnt_q        <= lcnt_d;
                v_valid_q     <= v_valid_d;
                vw_cnt_q      <= vw_cnt_d;
                vw_armed_q    <= vw_armed_d;
                frame_bad_q   <= frame_bad_d;
                good_q        <= good_d;
                locked_q      <= locked_d;
                line_len_q    <= line_len_d;
                frame_lines_q <= frame_lines_d;
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign video_on    = locked_q && (x_q < HD_L) && (y_q < VD_L);

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - self-checking bench for vga_sync_monitor
module tb_vga_sync_monitor;

    localparam int HD = 16, HT = 24, HSS = 18, HSW = 3;
    localparam int VD = 8, VT = 12, VSS = 9, VSW = 2, LF = 2;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0, reset_n = 1'b1, p_tick = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [9:0] x, y, line_len, frame_lines;
    logic video_on, locked, frame_start, h_err, v_err;

    vga_sync_monitor #(
        .HD(HD), .HTOTAL(HT), .HSYNC_START(HSS), .HSYNC_W(HSW),
        .VD(VD), .VTOTAL(VT), .VSYNC_START(VSS), .VSYNC_W(VSW),
        .SYNC_ACTIVE(1), .LOCK_FRAMES(LF)
    ) dut (
        .clk_100MHz(clk), .reset_n(reset_n), .p_tick(p_tick),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .video_on(video_on), .locked(locked),
        .frame_start(frame_start), .h_err(h_err), .v_err(v_err),
        .line_len(line_len), .frame_lines(frame_lines)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: periods and widths from tick timestamps
    int n, last_hr, hr_t, ph, pv, hval, hwarm, mx, my, lcnt, vval, vw, vwarm, fbad, good;
    int e_line, e_frame, e_lock, e_fs, e_herr, e_verr, ev_hr, ev_vr;

    task automatic model_reset;
        n = 0; last_hr = 0; hr_t = 0; ph = 0; pv = 0; hval = 0; hwarm = 0;
        mx = 0; my = 0; lcnt = 0; vval = 0; vw = 0; vwarm = 0; fbad = 0; good = 0;
        e_line = 0; e_frame = 0; e_lock = 0; e_fs = 0; e_herr = 0; e_verr = 0;
        ev_hr = 0; ev_vr = 0;
    endtask

    task automatic model_idle;
        e_fs = 0; e_herr = 0; e_verr = 0;
    endtask

    task automatic model_tick(input int h, input int v);
        int hr, hf, vr, vf, per, wid, ox, oy, vprev, err;
        n++;
        hr = h && !ph; hf = !h && ph; vr = v && !pv; vf = !v && pv;
        e_herr = 0; e_verr = 0;
        if (hr) begin
            per = n - last_hr;
            if (hval) begin
                e_line = (per > 1023) ? 1023 : per;
                if (per != HT) e_herr = 1;
            end
            hval = 1; last_hr = n; hr_t = n; hwarm = 1;
        end else if (n - last_hr == 1023) begin
            e_herr = 1; hval = 0;
        end
        wid = (n - hr_t > 1023) ? 1023 : n - hr_t;
        if (hf && hwarm && wid != HSW) e_herr = 1;
        ox = mx; oy = my;
        if (hr) mx = HSS;
        else if (mx == HT - 1) begin mx = 0; my = (my + 1) % VT; end
        else mx++;
        vprev = vval;
        if (vr) begin
            if (vval) begin
                e_frame = lcnt;
                if (lcnt != VT) e_verr = 1;
            end
            vval = 1; my = VSS; lcnt = hr; vw = hr; vwarm = 1;
        end else begin
            if (hr && lcnt < 1023) lcnt++;
            if (hr && v && vw < 1023) vw++;
        end
        if (vf && vwarm && vw != VSW) e_verr = 1;
        err = e_herr || e_verr;
        if (err) good = 0;
        if (vr) begin
            if (!err && vprev && !fbad && good < LF) good++;
            fbad = 0;
        end else if (err) fbad = 1;
        e_lock = (good == LF);
        e_fs = e_lock && mx == 0 && my == 0 && !(ox == 0 && oy == 0);
        ph = h; pv = v; ev_hr = hr; ev_vr = vr;
    endtask

    // Compare process: every clock, away from the active edge
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("x", int'(x), mx);
            check("y", int'(y), my);
            check("video_on", int'(video_on), int'(e_lock && mx < HD && my < VD));
            check("locked", int'(locked), e_lock);
            check("frame_start", int'(frame_start), e_fs);
            check("h_err", int'(h_err), e_herr);
            check("v_err", int'(v_err), e_verr);
            check("line_len", int'(line_len), e_line);
            check("frame_lines", int'(frame_lines), e_frame);
        end
    end

    // Source: VGA-timed generator with fault knobs
    int sx, sy, s_len = HT, short_pend = 0, hs_kill = 0, vsw_cur = VSW;
    int cur_sx, cur_sy, t_herr, t_verr, t_fs;

    task automatic do_tick;
        int h, v;
        @(negedge clk);
        h = (!hs_kill && sx >= HSS && sx < HSS + HSW) ? 1 : 0;
        v = (sy >= VSS && sy < VSS + vsw_cur) ? 1 : 0;
        hsync_in = h[0]; vsync_in = v[0]; p_tick = 1'b1;
        model_tick(h, v);
        cur_sx = sx; cur_sy = sy;
        if (sx == s_len - 1) begin
            sx = 0; sy = (sy + 1) % VT;
            s_len = short_pend ? HT - 1 : HT; short_pend = 0;
        end else sx++;
        @(posedge clk); #2;
        t_herr = int'(h_err); t_verr = int'(v_err); t_fs = int'(frame_start);
        repeat (3) begin
            @(negedge clk); p_tick = 1'b0; model_idle;
        end
    endtask

    task automatic lock_phase(input string tag);
        int vc = 0;
        for (int i = 0; i < 6 * FRAME && vc < 3; i++) begin
            do_tick;
            if (ev_vr) begin
                vc++;
                if (vc == 2) check({tag, "_locked_at_vedge2"}, int'(locked), 0);
                if (vc == 3) check({tag, "_locked_at_vedge3"}, int'(locked), 1);
            end
        end
        if (vc < 3) check({tag, "_vedge_budget"}, vc, 3);
    endtask

    task automatic align_line_start;
        for (int i = 0; i < 2 * HT && sx != 0; i++) do_tick;
    endtask

    initial begin
        int cnt, first, sv_x, sv_y, sv_ll, sv_fl, sv_lk;
        model_reset;
        sx = 5; sy = 3;
        #1 reset_n = 1'b0;
        chk_en = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_x", int'(x), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_line_len", int'(line_len), 0);
        check("rst_frame_lines", int'(frame_lines), 0);
        @(negedge clk); reset_n = 1'b1;

        // Nominal stream: lock at 3rd vsync edge, then exact tracking
        lock_phase("nom");
        cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            do_tick;
            check("track_x", int'(x), cur_sx);
            check("track_y", int'(y), cur_sy);
            cnt += t_fs;
        end
        check("frame_start_count", cnt, 2);
        check("nom_line_len", int'(line_len), HT);
        check("nom_frame_lines", int'(frame_lines), VT);

        // Reset mid-frame
        repeat (100) do_tick;
        @(negedge clk); reset_n = 1'b0; model_reset;
        #1;
        check("midrst_x", int'(x), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_line_len", int'(line_len), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        lock_phase("midrst");

        // One short line while locked
        short_pend = 1; cnt = 0;
        for (int i = 0; i < 3 * HT; i++) begin
            do_tick;
            if (t_herr) begin
                cnt++;
                check("short_locked", int'(locked), 0);
                check("short_line_len", int'(line_len), HT - 1);
            end
        end
        check("short_herr_count", cnt, 1);
        lock_phase("relock");

        // Hsync held inactive: timeout 1023 ticks after the last edge
        align_line_start;
        hs_kill = 1; cnt = 0; first = -1;
        for (int i = 0; i < 1100; i++) begin
            do_tick;
            if (t_herr) begin
                cnt++;
                if (first < 0) first = i;
                check("tmo_locked", int'(locked), 0);
            end
        end
        check("tmo_herr_count", cnt, 1);
        check("tmo_tick", first, 1023 - (HT - HSS));
        align_line_start;
        hs_kill = 0;
        for (int i = 0; i < 2 * HT && !ev_hr; i++) do_tick;
        check("tmo_edge_seen", ev_hr, 1);
        check("tmo_line_len_kept", int'(line_len), HT);
        for (int i = 0; i < 8 * FRAME && !locked; i++) do_tick;
        check("tmo_relocked", int'(locked), 1);

        // Vsync three lines wide
        for (int i = 0; i < 2 * FRAME && !(sx == 0 && sy == 0); i++) do_tick;
        vsw_cur = 3; cnt = 0;
        for (int i = 0; i < 300; i++) begin
            do_tick;
            if (t_verr) begin
                cnt++;
                check("vw_locked", int'(locked), 0);
                check("vw_video_on", int'(video_on), 0);
            end
        end
        check("vw_verr_count", cnt, 1);
        vsw_cur = VSW;

        // p_tick held low while syncs toggle
        sv_x = mx; sv_y = my; sv_ll = e_line; sv_fl = e_frame; sv_lk = e_lock;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            p_tick = 1'b0;
            hsync_in = 1'($urandom_range(0, 1));
            vsync_in = 1'($urandom_range(0, 1));
            model_idle;
        end
        #1;
        check("hold_x", int'(x), sv_x);
        check("hold_y", int'(y), sv_y);
        check("hold_line_len", int'(line_len), sv_ll);
        check("hold_frame_lines", int'(frame_lines), sv_fl);
        check("hold_locked", int'(locked), sv_lk);

        @(negedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side counterpart of the VGA timing generator. Samples an incoming hsync/vsync pair on the 25 MHz pixel tick and recovers the pixel coordinates x/y and a video_on window. It measures line and frame periods and sync widths, and declares lock after consecutive clean frames. It sits between any VGA-timed source (internal generator loopback, external capture front end) and pixel-consuming logic that needs coordinates aligned to received sync.

## Interface
Parameters:
- HD, 640: active pixels per line
- HTOTAL, 800: pixel ticks per line
- HSYNC_START, 656: x value at hsync assertion
- HSYNC_W, 96: hsync width in ticks
- VD, 480: active lines per frame
- VTOTAL, 525: lines per frame
- VSYNC_START, 513: y value at vsync assertion
- VSYNC_W, 2: vsync width in lines (counted as hsync assertion edges while vsync asserted)
- SYNC_ACTIVE, 1: level meaning "sync asserted" on both sync inputs
- LOCK_FRAMES, 2: clean frames required for lock

Ports:
- clk_100MHz  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- p_tick  in  1  pixel enable, one clk_100MHz cycle in four
- hsync_in  in  1  received horizontal sync
- vsync_in  in  1  received vertical sync
- x  out  10  recovered horizontal position, 0..HTOTAL-1
- y  out  10  recovered vertical position, 0..VTOTAL-1
- video_on  out  1  locked && x<HD && y<VD (combinational from registers)
- locked  out  1  timing lock
- frame_start  out  1  one-clock pulse when (x,y) becomes (0,0) while locked
- h_err  out  1  one-clock pulse on a horizontal timing violation
- v_err  out  1  one-clock pulse on a vertical timing violation
- line_len  out  10  last measured hsync period in ticks, saturating at 1023
- frame_lines  out  10  last measured hsync-edge count between vsync edges

## Operation
- Every state update happens only on clk_100MHz edges where p_tick=1. Between ticks, all registers hold.
- Each tick registers hs_q/vs_q. An assertion edge is input==SYNC_ACTIVE && q!=SYNC_ACTIVE. A deassertion edge is the reverse.
- hcnt (10b): 0 on an hsync assertion edge, otherwise +1, saturating at 1023.
- On an hsync assertion edge:
  - period = hcnt+1.
  - If a previous edge is valid: line_len<=period, and h_err fires if period≠HTOTAL.
  - The previous edge becomes valid.
  - x<=HSYNC_START.
- Hsync deassertion edge: h_err fires if the width counter ≠ HSYNC_W.
- Timeout: on the tick where hcnt reaches 1023, h_err fires and the previous-edge-valid flag clears.
- x with no hsync edge: +1 per tick, wrapping HTOTAL-1→0. On each wrap, y increments, wrapping VTOTAL-1→0.
- lcnt counts hsync assertion edges since the last vsync assertion edge.
- On a vsync assertion edge:
  - If a previous vsync edge is valid: frame_lines<=lcnt, and v_err fires if lcnt≠VTOTAL.
  - y<=VSYNC_START. This overrides a same-tick y increment.
  - lcnt<=0. If an hsync edge occurs on the same tick, it counts into the new frame: lcnt<=1.
- Vsync deassertion edge: v_err fires if the number of hsync edges seen while vsync was asserted ≠ VSYNC_W.
- Lock logic:
  - A sticky frame_bad flag sets on any h_err or v_err.
  - At each vsync assertion edge after the first: if frame_bad is clear, good_cnt increments, saturating at LOCK_FRAMES. frame_bad then clears.
  - locked=1 when good_cnt==LOCK_FRAMES.
  - Any h_err or v_err clears good_cnt and locked on the same clock.

## Timing
- Reset (async, reset_n=0): every output and internal register is 0, including x, y, locked, errors, line_len, frame_lines and both previous-edge-valid flags.
- Latency: x/y reflect a sync edge on the clock of the tick that samples it; there is one tick of input registration, and no extra latency.
- h_err, v_err and frame_start are exactly one clk_100MHz cycle wide. They never stretch over the four-cycle tick interval.
- The locked drop and the error pulse appear on the same clock edge.
- Simultaneous hsync and vsync edges: both are processed on the same tick.
- Reset released mid-frame: the block treats the stream as fresh. The first edges only arm the comparisons.
- Nominal stream: lock asserts at the third vsync assertion edge after reset (edge 1 arms, edges 2 and 3 are clean).

## Test plan
- Nominal 800×525 stream, sync asserted at x=656 for 96 ticks and y=513 for 2 lines -> locked=1 at the 3rd vsync edge; line_len=800; frame_lines=525; x/y track the source exactly; frame_start pulses once per frame.
- reset_n low for 3 clocks mid-frame -> all outputs 0 immediately; after release, locked stays 0 until the 3rd vsync edge.
- One 799-tick line while locked -> h_err single-cycle pulse at that hsync edge; line_len=799; locked=0 on the same clock; relock at the 2nd clean vsync edge afterwards.
- Hsync held inactive -> h_err pulse on the tick where hcnt reaches 1023; locked=0; the next hsync edge does not update line_len.
- Vsync width 3 lines -> v_err at vsync deassertion; locked=0; video_on=0.
- p_tick held low for 100 clocks while sync inputs toggle -> x, y, counters and outputs unchanged.
